mult_seq_ctrl: RTL
==================

Name: mult_seq_ctrl

Overview:
- FSM controller that sequences the shift-add multiplier datapath in the ELM neuron MAC path.
- Datapath: PIPO holding registers for multiplicand A and multiplier B, a product/accumulator register P, and the adder.
- The block accepts operands via a valid/ready handshake, drives load/clear/add/shift strobes for M iterations, and presents the result with a valid/ready handshake toward the hidden-layer accumulator.
- Pure control: it carries no operand data, and only observes the multiplier LSB from the datapath.

Parameters:
- N, 16, multiplicand width. Informational only; passed through to the datapath.
- M, 16, multiplier width; equals the number of add/shift iterations.
- CNT_W, $clog2(M+1), width of the iteration counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands A/B are present on the datapath inputs.
- in_ready  out  1  controller can accept operands.
- q0  in  1  current LSB of the multiplier shift register.
- ld_a  out  1  load enable for the multiplicand PIPO.
- ld_b  out  1  load enable for the multiplier register.
- clr_p  out  1  synchronous clear of the product register.
- add_en  out  1  add the multiplicand into the upper half of P this cycle.
- shift_en  out  1  shift P/B right by one this cycle.
- out_valid  out  1  product in P is final.
- out_ready  in  1  consumer accepts the product.
- busy  out  1  high whenever the state is not IDLE.
- iter  out  CNT_W  remaining iterations (debug/observability).

Behaviour:
- States: IDLE, LOAD, ITER, DONE. Two-bit registered state. All outputs are decoded from the registered state and counter, i.e. Moore-style, except add_en, which equals q0 during ITER.
- Reset (rst=0, asynchronous):
  - state=IDLE, iter=0.
  - All strobes, out_valid and busy are 0; in_ready=1 after reset is released.
  - Reset mid-operation abandons the multiply immediately. No partial out_valid is produced.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready → LOAD.
- LOAD (exactly 1 cycle):
  - ld_a=1, ld_b=1, clr_p=1; iter loaded with M.
  - Next state: ITER.
- ITER (exactly M cycles):
  - shift_en=1; add_en=q0; iter decrements each cycle.
  - When iter==1 in this cycle → DONE (the last iteration still shifts).
  - add_en and shift_en in the same cycle: the datapath adds then shifts (combined update).
- DONE:
  - out_valid=1, held stable with no strobes active until out_ready=1.
  - On the out_ready cycle → IDLE.
  - in_ready stays 0 in DONE. There is no overlap of the next operand load with result drain.
- Latency:
  - Handshake at cycle T, LOAD at T+1, ITER at T+2…T+M+1, out_valid first high at T+M+2.
  - Throughput: 1 product per M+3 cycles when out_ready is held 1.
- in_valid while busy is ignored; the upstream holds it.
- out_ready while not in DONE has no effect.
- M=1 is legal: ITER lasts exactly 1 cycle.
- iter never underflows; it reads 0 in IDLE and DONE.

Decomposition:
- Shared package mult_pkg:
  - state enum (IDLE=2'd0, LOAD=2'd1, ITER=2'd2, DONE=2'd3).
  - default N/M widths, reused by the datapath and its PIPO instances.
- One natural sub-module: mult_iter_cnt, a loadable down-counter with load/dec/zero-flag, also reusable by other sequential datapaths.
- The FSM stays in the top module.

Test Plan:
- Reset: hold rst=0 for 3 cycles with in_valid=1 → in_ready=0, all strobes 0. After release, in_ready=1, state IDLE, iter=0.
- Single multiply (M=16, B=16'h0005 so the q0 sequence is 1,0,1,0…0): in_valid at T.
  - ld_a/ld_b/clr_p high only at T+1.
  - shift_en high T+2…T+17; add_en high only at T+2 and T+4.
  - out_valid at T+18; with the datapath model and A=3, P=15.
- Backpressure: keep out_ready=0 for 5 cycles in DONE → out_valid stays 1, no strobes fire, in_ready=0. Raise out_ready → IDLE on the next cycle.
- Back-to-back: in_valid and out_ready tied to 1 → in_ready pulses every 19 cycles. Ten operand pairs give ten correct products matching the reference model.
- Reset mid-ITER: drop rst at T+8 → outputs clear immediately, no out_valid. The next multiply (A=7, B=9) yields 63 with normal latency.
- Edge operands: B=0 gives add_en never high and P=0. B=16'hFFFF, A=16'hFFFF gives add_en high all 16 ITER cycles and P=32'hFFFE0001.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: controller states and
// default operand widths used by the datapath and its holding registers.
package mult_pkg;

  localparam int N_DEF = 16;
  localparam int M_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mult_iter_cnt.sv
// Loadable down-counter with zero flag; saturates at zero so it never wraps.
module mult_iter_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  assign zero = (count == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the shift-add multiplier: operand handshake, M add/shift
// iterations, then holds the product valid until the consumer takes it.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   LOAD  | load A/B, clear P, preset iteration counter to M
//   ITER  | shift every cycle, add when the multiplier LSB is set
//   DONE  | product final, out_valid held until out_ready
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int M     = M_DEF,
  parameter int CNT_W = $clog2(M + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             q0,
  output logic             ld_a,
  output logic             ld_b,
  output logic             clr_p,
  output logic             add_en,
  output logic             shift_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] iter
);

  state_t state;
  logic   cnt_zero;

  if (N < 1 || M < 1) begin : g_param_check
    $error("mult_seq_ctrl: N and M must be at least 1");
  end

  mult_iter_cnt #(.W(CNT_W)) u_iter_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (state == LOAD),
    .dec      (state == ITER),
    .load_val (CNT_W'(M)),
    .count    (iter),
    .zero     (cnt_zero)
  );

  // shift_en is high exactly in ITER, so this gates q0 to the iteration window
  assign add_en = shift_en & q0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      ld_a      <= 1'b0;
      ld_b      <= 1'b0;
      clr_p     <= 1'b0;
      shift_en  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            state    <= LOAD;
            in_ready <= 1'b0;
            ld_a     <= 1'b1;
            ld_b     <= 1'b1;
            clr_p    <= 1'b1;
            busy     <= 1'b1;
          end else begin
            in_ready <= 1'b1;
          end
        end
        LOAD: begin
          state    <= ITER;
          ld_a     <= 1'b0;
          ld_b     <= 1'b0;
          clr_p    <= 1'b0;
          shift_en <= 1'b1;
        end
        ITER: begin
          // cnt_zero is only a safety exit; the terminal count is iter == 1
          if (iter == CNT_W'(1) || cnt_zero) begin
            state     <= DONE;
            shift_en  <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
